demux_1x2_8bits: RTL
====================

// Module: demux_1x2_8bits
// PURPOSE
//  Receive-side counterpart of the 2x1 8-bit lane mux. Takes the single interleaved byte
//  stream (lane0 byte, then lane1 byte, repeating), splits it back into two lanes and
//  presents each recovered pair together. A small pair FIFO with a downstream ready
//  handshake absorbs back-pressure. Sits in the PHY receive path ahead of the per-lane logic.
// PARAMETERS
//  DATA_WIDTH  8  width of one lane byte
//  FIFO_DEPTH  4  pair-FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1           single clock, rising edge
//  Reset_L     in   1           asynchronous, active-low reset
//  data_in     in   DATA_WIDTH  interleaved byte stream
//  valid_in    in   1           data_in holds a byte this cycle
//  ready_in    in   1           downstream accepts the presented pair
//  data_out0   out  DATA_WIDTH  lane0 byte of the head pair
//  data_out1   out  DATA_WIDTH  lane1 byte of the head pair
//  valid_out0  out  1           head pair present (lane0)
//  valid_out1  out  1           head pair present (lane1); always equal to valid_out0
//  fifo_full   out  1           pair FIFO holds FIFO_DEPTH entries
//  overflow    out  1           sticky: a completed pair was dropped
// BEHAVIOUR
//  - Reset (async assert, sync release): sel=0, hold=0, FIFO empty, all outputs 0.
//    Reset mid-pair discards the held lane0 byte.
//  - Lane selector FSM, advances only on valid_in=1:
//    L0 (sel=0): hold<=data_in, go to L1.
//    L1 (sel=1): push {hold,data_in} into the FIFO, go to L0.
//  - valid_in=0 in either state: no change. A partial pair is held indefinitely.
//  - Push rule: push succeeds if !full OR a pop occurs the same cycle.
//    Otherwise the pair is dropped, overflow<=1 (cleared only by reset), and the FSM still returns to L0.
//  - Pop occurs when valid_out0 && ready_in.
//    Simultaneous push and pop at count==1 keeps count=1, and the new pair becomes the head next cycle.
//  - Latency: a pair whose lane1 byte is sampled at edge N appears on the outputs after edge N if the FIFO was empty.
//  - valid_out0=valid_out1=!empty. data_out0/1 = head entry when valid, else 0.
//  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
//    full: MSBs differ and LSBs are equal. empty: pointers are equal.
//  - No arithmetic on data; bytes pass bit-exact.
// STRUCTURE
//  - Shared include mux_demux_defs.vh: DATA_WIDTH default, lane encodings LANE0=1'b0 / LANE1=1'b1.
//    This file is common with the 2x1 mux.
//  - One sub-module: pair_fifo (synchronous FIFO, width 2*DATA_WIDTH, depth FIFO_DEPTH).
//    Its ports: push/pop/full/empty/head.
//  - Top level holds the selector FSM, the hold register and the overflow flag.
// TESTING
//  1 Reset: Reset_L=0 with random inputs -> all outputs 0, fifo_full=0, overflow=0.
//  2 Stream 00,03,01,04,02,05 with valid_in=1, ready_in=1 -> pairs (00,03),(01,04),(02,05).
//    Each pair appears 1 cycle after its lane1 byte.
//  3 Gaps: bytes 0A, idle 3 cycles, 0B -> single pair (0A,0B); no output during the gap.
//  4 ready_in=0, send 5 pairs (depth 4) -> fifo_full=1 after 4 pairs.
//    Pair 5 is dropped and overflow=1. Then ready_in=1 -> first 4 pairs drain in order; overflow stays 1.
//  5 Full FIFO, ready_in=1 on the same cycle a pair completes -> no drop.
//    overflow stays 0 and count stays 4.
//  6 Send lane0 byte 7E, assert Reset_L=0 mid-pair, release, then send 11,22 -> only pair (11,22) emerges.

Source files
------------

// File: rtl/demux_1x2_8bits_pkg.sv
// Shared definitions for the 2x1 lane mux / 1x2 lane demux pair:
// default lane width, FIFO depth and the lane selector encoding.
package demux_1x2_8bits_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  function automatic lane_e lane_next(input lane_e cur);
    return (cur == LANE0) ? LANE1 : LANE0;
  endfunction

endpackage

// File: rtl/demux_1x2_8bits_pair_fifo.sv
// pair_fifo: synchronous FIFO holding recovered lane pairs.
// Ports: clk, rst_n, push_i/data_i (write), pop_i (read), full_o, empty_o, head_o.
module pair_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty.
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic [AW:0]  wr_ptr_d;
  logic [AW:0]  rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // When full, a push with a pop overwrites the slot being popped;
  // the head is read combinationally before the edge, so this is safe.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/demux_1x2_8bits.sv
// 1x2 lane demux: splits an interleaved byte stream into lane pairs, queued in a pair FIFO.
// Ports: clk, Reset_L, data_in/valid_in (stream), ready_in, data_out0/1, valid_out0/1, fifo_full, overflow.
module demux_1x2_8bits
  import demux_1x2_8bits_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  Reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic                  valid_out0,
  output logic                  valid_out1,
  output logic                  fifo_full,
  output logic                  overflow
);

  localparam int PW = 2 * DATA_WIDTH;

  lane_e                 sel_q;
  lane_e                 sel_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] hold_d;
  logic                  overflow_q;

  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [PW-1:0] head;

  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      sel_q  <= LANE0;
      hold_q <= '0;
    end else begin
      sel_q  <= sel_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    sel_d  = sel_q;
    hold_d = hold_q;
    if (valid_in) begin
      sel_d = lane_next(sel_q);
      if (sel_q == LANE0) hold_d = data_in;
    end
  end

  // A completed pair lands if there is room or the head leaves this cycle.
  always_comb begin
    pop      = !empty && ready_in;
    push_req = valid_in && (sel_q == LANE1);
    push     = push_req && (!full || pop);
    drop     = push_req && !push;
  end

  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L)  overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  pair_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (Reset_L),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({hold_q, data_in}),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign valid_out0 = !empty;
  assign valid_out1 = !empty;
  assign data_out0  = empty ? '0 : head[PW-1:DATA_WIDTH];
  assign data_out1  = empty ? '0 : head[DATA_WIDTH-1:0];
  assign fifo_full  = full;
  assign overflow   = overflow_q;

endmodule
